demux1_8_seq: RTL and testbench

Registered 1-to-8 demultiplexer and frame assembler. It is the receive-side counterpart of the 8:1 data-flow mux: it takes one serial data bit per valid cycle and steers it onto one of eight output lines. The line is chosen either by an external 3-bit select or by an internal auto-incrementing slot counter. When all eight lines have been written, it presents an assembled 8-bit frame with a one-cycle valid pulse. It sits at the far end of a mux-driven serial link.

---
 rtl/demux1_8_seq.sv | 93 +++++++++
 tb/tb_demux1_8_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/demux1_8_seq.sv
// Registered 1-to-8 demultiplexer and frame assembler: steers one serial bit per
// valid cycle onto a channel line and emits an 8-bit frame once every channel is written.
module demux1_8_seq #(
    parameter int unsigned NCH     = 8,
    parameter logic [7:0]  RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       din_valid,
    input  logic       auto,
    input  logic [2:0] s,
    input  logic       flush,
    output logic [7:0] y,
    output logic [7:0] frame,
    output logic       frame_valid,
    output logic [2:0] slot,
    output logic [7:0] wr_mask
);

    localparam int unsigned CW = 3;
    localparam int unsigned DW = 8;

    logic [DW-1:0] y_q, y_d;
    logic [DW-1:0] frame_q, frame_d;
    logic          frame_valid_q, frame_valid_d;
    logic [CW-1:0] slot_q, slot_d;
    logic [DW-1:0] wr_mask_q, wr_mask_d;
    logic          auto_prev_q;

    logic          mode_chg_c;
    logic [CW-1:0] ch_c;
    logic [DW-1:0] onehot_c;
    logic [DW-1:0] mask_new_c;
    logic [DW-1:0] y_new_c;

    // A mode switch aborts the partial frame exactly like a flush.
    assign mode_chg_c = auto ^ auto_prev_q;
    assign ch_c       = auto ? slot_q : s;
    assign onehot_c   = DW'(1) << ch_c;
    assign mask_new_c = wr_mask_q | onehot_c;
    assign y_new_c    = (y_q & ~onehot_c) | ({DW{din}} & onehot_c);

    // Next-state logic: flush/mode change beats a write.
    always_comb begin
        y_d           = y_q;
        frame_d       = frame_q;
        frame_valid_d = 1'b0;
        slot_d        = slot_q;
        wr_mask_d     = wr_mask_q;
        if (flush || mode_chg_c) begin
            slot_d    = '0;
            wr_mask_d = '0;
        end else if (din_valid) begin
            y_d = y_new_c;
            if (auto) begin
                slot_d = slot_q + CW'(1);
            end
            if (mask_new_c == {DW{1'b1}}) begin
                frame_d       = y_new_c;
                frame_valid_d = 1'b1;
                wr_mask_d     = '0;
            end else begin
                wr_mask_d = mask_new_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q           <= RST_VAL;
            frame_q       <= RST_VAL;
            frame_valid_q <= 1'b0;
            slot_q        <= '0;
            wr_mask_q     <= '0;
            auto_prev_q   <= 1'b0;
        end else begin
            y_q           <= y_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            slot_q        <= slot_d;
            wr_mask_q     <= wr_mask_d;
            auto_prev_q   <= auto;
        end
    end

    assign y           = y_q;
    assign frame       = frame_q;
    assign frame_valid = frame_valid_q;
    assign slot        = slot_q;
    assign wr_mask     = wr_mask_q;

endmodule

// File: tb/tb_demux1_8_seq.sv
// Scoreboard bench for demux1_8_seq: a behavioural model pushes expected outputs
// per driven cycle; they are popped and compared one clock later.
module tb_demux1_8_seq;

    logic       clk = 1'b0;
    logic       rst, din, din_valid, auto, flush;
    logic [2:0] s;
    logic [7:0] y, frame, wr_mask;
    logic       frame_valid;
    logic [2:0] slot;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] y;
        logic [7:0] frame;
        logic       fv;
        logic [2:0] slot;
        logic [7:0] mask;
    } exp_t;

    exp_t sb_q[$];

    logic [7:0] m_y, m_frame, m_mask;
    logic       m_fv, m_prev;
    logic [2:0] m_slot;

    demux1_8_seq #(.NCH(8), .RST_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .auto(auto),
        .s(s), .flush(flush), .y(y), .frame(frame), .frame_valid(frame_valid),
        .slot(slot), .wr_mask(wr_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour, one clock edge.
    task automatic model(input logic r, d, v, a, input logic [2:0] sel, input logic f);
        int   ch;
        logic all;
        if (r) begin
            m_y = 8'h00; m_frame = 8'h00; m_fv = 1'b0; m_slot = 3'd0; m_mask = 8'h00; m_prev = 1'b0;
            return;
        end
        m_fv = 1'b0;
        if (f || (a != m_prev)) begin
            m_slot = 3'd0;
            m_mask = 8'h00;
        end else if (v) begin
            ch = a ? int'(m_slot) : int'(sel);
            m_y[ch]    = d;
            m_mask[ch] = 1'b1;
            if (a) m_slot = (m_slot == 3'd7) ? 3'd0 : m_slot + 3'd1;
            all = 1'b1;
            for (int i = 0; i < 8; i++) if (!m_mask[i]) all = 1'b0;
            if (all) begin
                m_frame = m_y;
                m_fv    = 1'b1;
                m_mask  = 8'h00;
            end
        end
        m_prev = a;
    endtask

    task automatic cyc(input logic r, d, v, a, input logic [2:0] sel, input logic f);
        exp_t e;
        rst = r; din = d; din_valid = v; auto = a; s = sel; flush = f;
        model(r, d, v, a, sel, f);
        e.y = m_y; e.frame = m_frame; e.fv = m_fv; e.slot = m_slot; e.mask = m_mask;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("y",           y,                  e.y);
        check("frame",       frame,              e.frame);
        check("frame_valid", 8'(frame_valid),    8'(e.fv));
        check("slot",        8'(slot),           8'(e.slot));
        check("wr_mask",     wr_mask,            e.mask);
    endtask

    logic [7:0] t1_bits;
    logic [2:0] t2_sel [8];
    logic [7:0] t2_mask [8];
    logic [7:0] y_snap;

    initial begin
        t1_bits = 8'b0100_1101;
        t2_sel  = '{3'd7, 3'd3, 3'd0, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4};
        t2_mask = '{8'h80, 8'h88, 8'h89, 8'hA9, 8'hAB, 8'hEB, 8'hEF, 8'h00};

        // Reset state
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 0, 0);
        check("rst_y", y, 8'h00);
        check("rst_frame", frame, 8'h00);

        // 1: auto mode frame; first auto=1 cycle is a mode change
        cyc(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, t1_bits[i], 1, 1, 0, 0);
            check("t1_fv", 8'(frame_valid), (i == 7) ? 8'h01 : 8'h00);
        end
        check("t1_frame", frame, 8'b0100_1101);
        check("t1_slot", 8'(slot), 8'h00);
        cyc(0, 0, 0, 1, 0, 0);
        check("t1_fv_drop", 8'(frame_valid), 8'h00);

        // 2: addressed mode, scrambled order, all ones
        cyc(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 1, 0, t2_sel[i], 0);
            check("t2_mask", wr_mask, t2_mask[i]);
        end
        check("t2_frame", frame, 8'hFF);

        // 3: rewrites of channel 2 do not complete the frame
        cyc(0, 1, 1, 0, 3'd2, 0);
        cyc(0, 0, 1, 0, 3'd2, 0);
        cyc(0, 1, 1, 0, 3'd2, 0);
        check("t3_mask", wr_mask, 8'h04);
        for (int c = 0; c < 8; c++) begin
            if (c != 2) cyc(0, 0, 1, 0, 3'(c), 0);
        end
        check("t3_frame", frame, 8'h04);
        check("t3_fv", 8'(frame_valid), 8'h01);

        // 4: flush in auto mode mid-frame
        cyc(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 1, 0, 0);
        y_snap = y;
        cyc(0, 0, 1, 1, 0, 1);
        check("t4_slot", 8'(slot), 8'h00);
        check("t4_mask", wr_mask, 8'h00);
        check("t4_y_hold", y, y_snap);
        check("t4_no_fv", 8'(frame_valid), 8'h00);
        for (int i = 0; i < 8; i++) cyc(0, i[0], 1, 1, 0, 0);
        check("t4_frame", frame, 8'hAA);

        // 5: mode toggle drops the write
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1, 0, 0);
        y_snap = y;
        cyc(0, ~y_snap[4], 1, 0, 3'd4, 0);
        check("t5_y4", 8'(y[4]), 8'(y_snap[4]));
        check("t5_mask", wr_mask, 8'h00);

        // 6: reset mid-frame, then idle hold
        cyc(0, 1, 1, 0, 3'd1, 0);
        cyc(0, 1, 1, 0, 3'd6, 0);
        cyc(1, 1, 1, 0, 3'd3, 0);
        check("t6_y", y, 8'h00);
        check("t6_mask", wr_mask, 8'h00);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 3'(i), 0);

        // Random traffic with occasional flush, mode flips and reset
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 99) == 0), 1'($urandom), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 29) == 0) ? ~m_prev : m_prev,
                3'($urandom), ($urandom_range(0, 39) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
